// File: rtl/pkt_proc_deq_pkg.sv
// Shared types and default sizing for the packet-processor dequeue controller.
package pkt_proc_deq_pkg;

  localparam int DEQ_DATA_W     = 32;
  localparam int DEQ_SKID_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    PKT  = 2'd2
  } deq_state_e;

  typedef struct packed {
    logic [DEQ_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
  } deq_word_t;

endpackage

// File: rtl/pkt_proc_deq_ctrl_if.sv
// Bus bundles for pkt_proc_deq_ctrl: FIFO read side and egress stream side.
interface pkt_deq_fifo_if #(parameter int DATA_W = 32);
  logic              deq_req;
  logic              pck_proc_empty;
  logic [DATA_W-1:0] rd_data_o;
  logic              out_sop;
  logic              out_eop;

  modport master (output deq_req, input pck_proc_empty, rd_data_o, out_sop, out_eop);
  modport slave  (input deq_req, output pck_proc_empty, rd_data_o, out_sop, out_eop);
endinterface

// Valid/ready: a word moves on a cycle where m_valid && m_ready; while m_valid
// is high and m_ready low, m_data/m_sop/m_eop stay stable and m_valid stays high.
interface pkt_deq_stream_if #(parameter int DATA_W = 32);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sop;
  logic              m_eop;

  modport master (output m_valid, m_data, m_sop, m_eop, input m_ready);
  modport slave  (input m_valid, m_data, m_sop, m_eop, output m_ready);
endinterface

// File: rtl/pkt_deq_skid_fifo.sv
// Circular skid buffer of deq_word_t; clr_n is a synchronous clear equal to reset.
module pkt_deq_skid_fifo
  import pkt_proc_deq_pkg::*;
#(
  parameter int  DEPTH = DEQ_SKID_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int OW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_n,
  input  logic          wr_en,
  input  deq_word_t     wr_word,
  input  logic          rd_en,
  output deq_word_t     rd_word,
  output logic [OW-1:0] occ
);

  deq_word_t     mem_q [DEPTH];
  deq_word_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          do_rd;

  // Writes are unconditional: upstream credit guarantees a free slot.
  assign do_rd = rd_en && (occ_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (!clr_n) begin
      mem_d    = '{default: '0};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_word;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({wr_en, do_rd})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_word = mem_q[rd_ptr_q];
  assign occ     = occ_q;

endmodule

// File: rtl/pkt_proc_deq_ctrl.sv
// Packet FIFO drain stage: credit-based dequeue, SOP/EOP framing FSM, skid buffer.
// Define PKT_DEQ_STATS_EN to build the forwarded-packet counter on pkt_cnt.
module pkt_proc_deq_ctrl
  import pkt_proc_deq_pkg::*;
#(
  parameter int DATA_W     = DEQ_DATA_W,
  parameter int SKID_DEPTH = DEQ_SKID_DEPTH
) (
  input  logic                    pck_proc_int_mem_fsm_clk,
  input  logic                    pck_proc_int_mem_fsm_rstn,
  input  logic                    pck_proc_int_mem_fsm_sw_rstn,
  input  logic                    deq_en,
  pkt_deq_fifo_if.master          fifo_if,
  pkt_deq_stream_if.master        egr_if,
  output logic                    busy,
  output logic                    framing_err,
  input  logic                    err_clr,
  output logic [15:0]             pkt_cnt,
  output deq_state_e              dbg_state
);

  localparam int OW = $clog2(SKID_DEPTH) + 1;

  deq_state_e    state_q, state_d;
  logic          inflight_q, inflight_d;
  logic          framing_err_q, framing_err_d;
  logic          run, soft_clr, wr_en, rd_en, set_err;
  logic [OW-1:0] occ;
  logic [OW:0]   credit_used;
  deq_word_t     wr_word, rd_word;

  assign soft_clr    = !pck_proc_int_mem_fsm_sw_rstn;
  assign run         = (state_q != IDLE);
  assign credit_used = {1'b0, occ} + {{OW{1'b0}}, inflight_q};

  // Words already buffered plus the one in flight must leave room for this request.
  assign fifo_if.deq_req = run && !fifo_if.pck_proc_empty &&
                           (credit_used < (OW+1)'(SKID_DEPTH));

  assign wr_word.data = fifo_if.rd_data_o;
  assign wr_word.sop  = fifo_if.out_sop;
  assign wr_word.eop  = fifo_if.out_eop;

  always_comb begin
    state_d       = state_q;
    wr_en         = 1'b0;
    set_err       = 1'b0;
    inflight_d    = fifo_if.deq_req;
    case (state_q)
      IDLE: begin
        if (deq_en) state_d = HUNT;
      end
      HUNT: begin
        if (inflight_q) begin
          if (fifo_if.out_sop) begin
            wr_en = 1'b1;
            if (!fifo_if.out_eop) state_d = PKT;
          end else begin
            set_err = 1'b1;
          end
        end else if (!deq_en) begin
          state_d = IDLE;
        end
      end
      PKT: begin
        // deq_en is ignored here so a packet is never cut short.
        if (inflight_q) begin
          wr_en = 1'b1;
          if (fifo_if.out_sop) set_err = 1'b1;
          if (fifo_if.out_eop) state_d = HUNT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_clr)      framing_err_d = 1'b0;
    else if (set_err) framing_err_d = 1'b1;
    else              framing_err_d = framing_err_q;

    if (soft_clr) begin
      state_d       = IDLE;
      inflight_d    = 1'b0;
      framing_err_d = 1'b0;
      wr_en         = 1'b0;
    end
  end

  always_ff @(posedge pck_proc_int_mem_fsm_clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) begin
      state_q       <= IDLE;
      inflight_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      framing_err_q <= framing_err_d;
    end
  end

  pkt_deq_skid_fifo #(
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (pck_proc_int_mem_fsm_clk),
    .rst_n   (pck_proc_int_mem_fsm_rstn),
    .clr_n   (pck_proc_int_mem_fsm_sw_rstn),
    .wr_en   (wr_en),
    .wr_word (wr_word),
    .rd_en   (rd_en),
    .rd_word (rd_word),
    .occ     (occ)
  );

  assign egr_if.m_valid = (occ != '0);
  assign egr_if.m_data  = rd_word.data[DATA_W-1:0];
  assign egr_if.m_sop   = rd_word.sop;
  assign egr_if.m_eop   = rd_word.eop;
  assign rd_en          = egr_if.m_valid && egr_if.m_ready;

  assign busy        = run || (occ != '0) || inflight_q;
  assign framing_err = framing_err_q;
  assign dbg_state   = state_q;

`ifdef PKT_DEQ_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (rd_en && rd_word.eop) pkt_cnt_d = pkt_cnt_q + 16'd1;
    if (soft_clr)             pkt_cnt_d = '0;
  end

  always_ff @(posedge pck_proc_int_mem_fsm_clk or negedge pck_proc_int_mem_fsm_rstn) begin
    if (!pck_proc_int_mem_fsm_rstn) pkt_cnt_q <= '0;
    else                            pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule
